// File: rtl/decompressor_feed_if.sv
// Byte-stream and item-issue signals between the LZRW1 feed controller and its neighbours.
// master = feed controller side, slave = byte source / decompressor side.
interface decompressor_feed_if;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dec_data_in;
  logic        dec_control_word_in;
  logic        dec_data_in_valid;
  logic        dec_busy;
  logic        dec_out_valid;

  modport master (
    input  in_byte,
    input  in_valid,
    output in_ready,
    output dec_data_in,
    output dec_control_word_in,
    output dec_data_in_valid,
    input  dec_busy,
    input  dec_out_valid
  );

  modport slave (
    output in_byte,
    output in_valid,
    input  in_ready,
    input  dec_data_in,
    input  dec_control_word_in,
    input  dec_data_in_valid,
    output dec_busy,
    output dec_out_valid
  );
endinterface

// File: rtl/decompressor_feed_ctrl.sv
// Turns a raw LZRW1 compressed byte stream into literal/copy items for decompressor_top.
// Optional DECOMP_FEED_STATS_EN adds items_issued / bytes_out counters.
module decompressor_feed_ctrl #(
  parameter int unsigned LEN_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  decompressor_feed_if.master  feed,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] job_len,
  output logic                 ctrl_busy,
  output logic                 done,
`ifdef DECOMP_FEED_STATS_EN
  output logic [LEN_WIDTH-1:0] items_issued,
  output logic [LEN_WIDTH-1:0] bytes_out,
`endif
  output logic                 err
);

  typedef enum logic [3:0] {
    StIdle,
    StCwLo,
    StCwHi,
    StItemB0,
    StItemB1,
    StIssue,
    StGap,
    StDrain,
    StFin
  } state_e;

  state_e               state_q, state_d;
  logic [LEN_WIDTH-1:0] remaining_q, remaining_d;
  logic [15:0]          cw_q, cw_d;
  logic [3:0]           k_q, k_d;
  logic [7:0]           b0_q, b0_d;
  logic [15:0]          data_q, data_d;
  logic                 flag_q, flag_d;
  logic                 err_q, err_d;

  logic                 in_ready_w;
  logic                 accept;
  logic                 rem_last;
  logic [LEN_WIDTH-1:0] rem_dec;

  // in_ready is a pure function of state so it never loops back through in_valid.
  always_comb begin
    in_ready_w = 1'b0;
    unique case (state_q)
      StCwLo, StCwHi, StItemB0, StItemB1: in_ready_w = 1'b1;
      default:                             in_ready_w = 1'b0;
    endcase
  end

  assign accept   = feed.in_valid & in_ready_w;
  assign rem_dec  = remaining_q - LEN_WIDTH'(1);
  assign rem_last = (remaining_q == LEN_WIDTH'(1));

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    cw_d        = cw_q;
    k_d         = k_q;
    b0_d        = b0_q;
    data_d      = data_q;
    flag_d      = flag_q;
    err_d       = err_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          remaining_d = job_len;
          err_d       = 1'b0;
          state_d     = (job_len == '0) ? StFin : StCwLo;
        end
      end

      StCwLo: begin
        if (accept) begin
          cw_d[7:0]   = feed.in_byte;
          remaining_d = rem_dec;
          if (rem_last) begin
            err_d   = 1'b1;
            state_d = StDrain;
          end else begin
            state_d = StCwHi;
          end
        end
      end

      StCwHi: begin
        if (accept) begin
          cw_d[15:8]  = feed.in_byte;
          remaining_d = rem_dec;
          k_d         = 4'd0;
          // A control word with nothing after it is a legal empty group.
          state_d     = rem_last ? StDrain : StItemB0;
        end
      end

      StItemB0: begin
        if (accept) begin
          remaining_d = rem_dec;
          if (!cw_q[k_q]) begin
            data_d  = {8'h00, feed.in_byte};
            flag_d  = 1'b0;
            state_d = StIssue;
          end else begin
            b0_d = feed.in_byte;
            if (rem_last) begin
              err_d   = 1'b1;
              state_d = StDrain;
            end else begin
              state_d = StItemB1;
            end
          end
        end
      end

      StItemB1: begin
        if (accept) begin
          remaining_d = rem_dec;
          data_d      = {b0_q, feed.in_byte};
          flag_d      = 1'b1;
          state_d     = StIssue;
        end
      end

      StIssue: begin
        if (!feed.dec_busy) begin
          state_d = StGap;
        end
      end

      // Dead cycle: the decompressor may raise busy only the cycle after acceptance.
      StGap: begin
        if (remaining_q == '0) begin
          state_d = StDrain;
        end else if (k_q == 4'd15) begin
          state_d = StCwLo;
        end else begin
          k_d     = k_q + 4'd1;
          state_d = StItemB0;
        end
      end

      StDrain: begin
        if (!feed.dec_busy) begin
          state_d = StFin;
        end
      end

      StFin: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      cw_q        <= '0;
      k_q         <= '0;
      b0_q        <= '0;
      data_q      <= '0;
      flag_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      cw_q        <= cw_d;
      k_q         <= k_d;
      b0_q        <= b0_d;
      data_q      <= data_d;
      flag_q      <= flag_d;
      err_q       <= err_d;
    end
  end

  assign feed.in_ready            = in_ready_w;
  assign feed.dec_data_in         = data_q;
  assign feed.dec_control_word_in = flag_q;
  assign feed.dec_data_in_valid   = (state_q == StIssue);
  assign ctrl_busy                = (state_q != StIdle);
  assign done                     = (state_q == StFin);
  assign err                      = (state_q == StFin) & err_q;

`ifdef DECOMP_FEED_STATS_EN
  logic                 job_start;
  logic                 issue_fire;
  logic [LEN_WIDTH-1:0] items_q;
  logic [LEN_WIDTH-1:0] bytes_q;

  assign job_start  = (state_q == StIdle) & start;
  assign issue_fire = (state_q == StIssue) & ~feed.dec_busy;

  always_ff @(posedge clock) begin
    if (reset || job_start) begin
      items_q <= '0;
      bytes_q <= '0;
    end else begin
      if (issue_fire) begin
        items_q <= items_q + LEN_WIDTH'(1);
      end
      if (feed.dec_out_valid && ctrl_busy) begin
        bytes_q <= bytes_q + LEN_WIDTH'(1);
      end
    end
  end

  assign items_issued = items_q;
  assign bytes_out    = bytes_q;
`endif

endmodule

// File: doc/decompressor_feed_ctrl.md
# decompressor_feed_ctrl

- Sequences the LZRW1 decompressor datapath by turning a raw compressed byte stream into the item-at-a-time interface that `decompressor_top` accepts.
- Pulls bytes from an upstream reader over a valid/ready handshake and unpacks each 16-bit control word into per-item flags.
- Assembles literal and copy items and issues them one by one, respecting `decompressor_busy`; signals job completion or truncation.

## Interface
- `LEN_WIDTH`, 16, width of the compressed job length and internal byte counter.
- `clock` in 1, the single clock.
- `reset` in 1, synchronous, active-high.
- `start` in 1, one-cycle job start; sampled only in IDLE.
- `job_len` in LEN_WIDTH, compressed job length in bytes (control words included); captured on accepted `start`.
- `ctrl_busy` out 1, high from accepted `start` through the `done` cycle.
- `done` out 1, one-cycle pulse at job end.
- `err` out 1, one-cycle pulse coincident with `done` when the stream is truncated.
- `in_byte` in 8, compressed stream byte.
- `in_valid` in 1, `in_byte` is valid.
- `in_ready` out 1, controller accepts `in_byte` this cycle.
- `dec_data_in` out 16, item to the decompressor's `data_in`.
- `dec_control_word_in` out 1, item flag to the decompressor's `control_word_in` (0 = literal, 1 = copy).
- `dec_data_in_valid` out 1, to the decompressor's `data_in_valid`.
- `dec_busy` in 1, from the decompressor's `decompressor_busy`.
- `dec_out_valid` in 1, from the decompressor's `out_valid`; used only with the stats macro.

## Operation
- **States:** IDLE, CW_LO, CW_HI, ITEM_B0, ITEM_B1, ISSUE, GAP, DRAIN, FIN.
- **Byte accept:** a byte is accepted when `in_valid & in_ready`. `in_ready` is 1 only in CW_LO, CW_HI, ITEM_B0 and ITEM_B1.
- **Byte counter:** `remaining` is loaded with `job_len` on start and decrements on every accepted byte.
- **IDLE:**
  - `start` → CW_LO, `remaining = job_len`.
  - If `job_len == 0`, go to FIN instead.
- **Control word:**
  - CW_LO: accepted byte → `cw[7:0]`.
  - CW_HI: accepted byte → `cw[15:8]`.
  - Item index `k` is reset to 0 on entering a group; item `k` uses `cw[k]` (LSB first).
- **Literal** (`cw[k] = 0`): ITEM_B0 accepts one byte → `dec_data_in = {8'h00, byte}`, then ISSUE.
- **Copy** (`cw[k] = 1`): ITEM_B0 accepts the high byte, ITEM_B1 accepts the low byte → `dec_data_in = {b0, b1}`, then ISSUE.
- **ISSUE:**
  - Drive `dec_data_in_valid = 1` with data and flag held stable.
  - The item is accepted on a cycle where `dec_data_in_valid & ~dec_busy`; on acceptance go to GAP.
  - While `dec_busy` is high, stay in ISSUE and keep all three outputs held.
- **GAP:**
  - One mandatory cycle with `dec_data_in_valid = 0`, because the decompressor may raise busy the cycle after acceptance.
  - Then, in priority order:
    - `remaining == 0` → DRAIN.
    - `k == 15` → CW_LO.
    - Otherwise `k++` → ITEM_B0.
- **Truncation:** reaching `remaining == 0` immediately after an accepted byte in CW_LO or ITEM_B0-for-copy sets the error flag and goes to DRAIN. The partial item is not issued.
- **End of stream after CW_HI:** `remaining == 0` after CW_HI is a legal empty group → DRAIN, no error.
- **DRAIN:** wait until `dec_busy == 0`, then go to FIN.
- **FIN:** `done = 1` for one cycle (`err = 1` with it if flagged), then IDLE.
- **Start while active:** `start` outside IDLE is ignored.
- **Reset:**
  - `reset` has priority over `start`.
  - Reset mid-job returns to IDLE and discards the partial job; no `done` is issued.
  - Reset values: every output 0, including `dec_data_in = 16'h0000`, `in_ready`, `ctrl_busy`, `done`, `err`; all counters 0.

## Timing
- An item's ISSUE cycle is the cycle after its last byte is accepted.
- Best-case throughput with `dec_busy` tied low and `in_valid` always high:
  - literal: 3 cycles (B0, ISSUE, GAP);
  - copy: 4 cycles;
  - control word: 2 cycles.
- `job_len = 0`: `done` pulses 1 cycle after `start`.
- Otherwise `done` pulses at least 1 cycle after DRAIN observes `dec_busy == 0`.
- `in_ready` does not depend combinationally on `in_valid`.

## Configuration
- **`DECOMP_FEED_STATS_EN` defined:**
  - Adds output `items_issued[LEN_WIDTH-1:0]`, counting accepted issues.
  - Adds output `bytes_out[LEN_WIDTH-1:0]`, counting `dec_out_valid` cycles while `ctrl_busy`.
  - Both clear on accepted `start` and on reset, and hold after `done`.
- **Undefined:** neither port exists, `dec_out_valid` is unused, and no counter logic is generated.

## Test plan
- **Empty job:** `job_len = 0`, pulse `start` → `done = 1` one cycle later, `err = 0`, `dec_data_in_valid` never 1.
- **Literals:** bytes `00 00 61 62 63`, `job_len = 5`, `dec_busy = 0` → three issues with `dec_data_in` = `0x0061`, `0x0062`, `0x0063` and flag 0; then `done`, `err = 0`.
- **Mixed group:** bytes `02 00 61 10 01`, `job_len = 5` → issue {`0x0061`, flag 0} then {`0x1001`, flag 1}; then `done`.
- **Backpressure:** mixed-group stream with `dec_busy` held high for 4 cycles before each accept → valid, data and flag held stable throughout; exactly one acceptance per item; no byte accepted while in ISSUE.
- **Truncation:** bytes `01 00 10`, `job_len = 3` → no item issued; `done` and `err` pulse together.
- **Group wrap and reset:**
  - `00 00` + 16 literals + `01 00 AA BB`, `job_len = 22` → 17 issues, the last being {`0xAABB`, flag 1}; with the stats macro defined, `items_issued = 17`.
  - Repeat the run and assert `reset` after the 5th issue → all outputs 0 next cycle; a fresh `start` works normally.
